// File: rtl/octave_decimator.sv
// Octave-to-octave decimator: keeps even columns of even rows and forwards every blanking beat.
// Row parity and end of frame are recovered from the pixel/blanking stream alone.
module octave_decimator #(
    parameter int unsigned IN_WIDTH   = 420,
    parameter int unsigned VBLANK_MIN = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       validin,
    input  logic       blanking_in,
    output logic [7:0] dout,
    output logic       validout,
    output logic       blanking_out,
    output logic       frame_done,
    output logic       error
);

    localparam int unsigned COL_W = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned BR_W  = $clog2(VBLANK_MIN + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [BR_W-1:0]  BR_MAX   = BR_W'(VBLANK_MIN);
    localparam logic [BR_W-1:0]  BR_PRE   = BR_W'(VBLANK_MIN - 1);

    localparam logic [1:0] WAIT_FRAME = 2'd0;
    localparam logic [1:0] EVEN_ROW   = 2'd1;
    localparam logic [1:0] ODD_ROW    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [BR_W-1:0]  blank_run_q, blank_run_d;
    logic [7:0]       dout_q, dout_d;
    logic             validout_q, validout_d;
    logic             blanking_out_q, blanking_out_d;
    logic             frame_done_q, frame_done_d;
    logic             error_q, error_d;

    logic [COL_W-1:0] col_eff;
    logic             keep;

    // First pixel after a frame boundary is always row 0 col 0.
    assign col_eff = (state_q == WAIT_FRAME) ? '0 : col_q;
    assign keep    = (state_q != ODD_ROW) && !col_eff[0];

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        blank_run_d    = blank_run_q;
        dout_d         = dout_q;
        validout_d     = 1'b0;
        blanking_out_d = 1'b0;
        frame_done_d   = 1'b0;
        error_d        = error_q;

        if (validin) begin
            if (!blanking_in) begin
                blank_run_d = '0;
                if (keep) begin
                    dout_d     = din;
                    validout_d = 1'b1;
                end
                if (col_eff == COL_LAST) begin
                    col_d   = '0;
                    state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end else begin
                    col_d = col_eff + COL_W'(1);
                    if (state_q == WAIT_FRAME) begin
                        state_d = EVEN_ROW;
                    end
                end
            end else begin
                validout_d     = 1'b1;
                blanking_out_d = 1'b1;
                dout_d         = 8'd0;
                if (col_q != '0) begin
                    error_d = 1'b1;
                    col_d   = '0;
                end
                // Saturating run counter; frame_done fires only on the crossing beat.
                if (blank_run_q != BR_MAX) begin
                    blank_run_d = blank_run_q + BR_W'(1);
                    if (blank_run_q == BR_PRE) begin
                        frame_done_d = 1'b1;
                        state_d      = WAIT_FRAME;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= WAIT_FRAME;
            col_q          <= '0;
            blank_run_q    <= '0;
            dout_q         <= 8'd0;
            validout_q     <= 1'b0;
            blanking_out_q <= 1'b0;
            frame_done_q   <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            blank_run_q    <= blank_run_d;
            dout_q         <= dout_d;
            validout_q     <= validout_d;
            blanking_out_q <= blanking_out_d;
            frame_done_q   <= frame_done_d;
            error_q        <= error_d;
        end
    end

    assign dout         = dout_q;
    assign validout     = validout_q;
    assign blanking_out = blanking_out_q;
    assign frame_done   = frame_done_q;
    assign error        = error_q;

endmodule
